dac_spi_arbiter: RTL



---
 rtl/dac_spi_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dac_spi_arbiter.sv
// Round-robin arbiter sharing one SPI serializer between two DAC requesters.
// Grants one 16-bit word at a time and shifts it MSB-first under that DAC's SYNC.
module dac_spi_arbiter #(
    parameter int CLK_DIV     = 10,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req1_valid_i,
    input  logic [15:0] req1_data_i,
    output logic        req1_ready_o,
    input  logic        req2_valid_i,
    input  logic [15:0] req2_data_i,
    output logic        req2_ready_o,
    output logic        dac1_sync_o,
    output logic        dac2_sync_o,
    output logic        sclk_o,
    output logic        sdi_o,
    output logic        busy_o,
    output logic        done1_o,
    output logic        done2_o
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, WAIT} state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic [WW-1:0] wait_cnt;
    logic [15:0]   shreg;
    logic          last_two;
    logic          grant1;
    logic          grant2;

    // last_two marks channel 2 as most recently served; it also names the active channel mid-frame
    always_comb begin
        grant1 = req1_valid_i & (~req2_valid_i | last_two);
        grant2 = req2_valid_i & (~req1_valid_i | ~last_two);
    end

    assign req1_ready_o = (state == IDLE) & grant1;
    assign req2_ready_o = (state == IDLE) & grant2;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            shreg       <= '0;
            last_two    <= 1'b1;
            dac1_sync_o <= 1'b1;
            dac2_sync_o <= 1'b1;
            sclk_o      <= 1'b1;
            sdi_o       <= 1'b0;
            busy_o      <= 1'b0;
            done1_o     <= 1'b0;
            done2_o     <= 1'b0;
        end else begin
            done1_o <= 1'b0;
            done2_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant1 | grant2) begin
                        shreg       <= grant1 ? req1_data_i : req2_data_i;
                        sdi_o       <= grant1 ? req1_data_i[15] : req2_data_i[15];
                        last_two    <= grant2;
                        dac1_sync_o <= ~grant1;
                        dac2_sync_o <= ~grant2;
                        busy_o      <= 1'b1;
                        div_cnt     <= DW'(CLK_DIV - 1);
                        bit_cnt     <= 4'd15;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_cnt == '0) begin
                        sclk_o  <= 1'b0;
                        div_cnt <= DW'(CLK_DIV - 1);
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt <= DW'(CLK_DIV - 1);
                        if (!sclk_o) begin
                            // rising SCLK: present the next bit unless this is bit 0
                            sclk_o <= 1'b1;
                            if (bit_cnt != 4'd0) begin
                                sdi_o <= shreg[14];
                                shreg <= {shreg[14:0], 1'b0};
                            end
                        end else if (bit_cnt == 4'd0) begin
                            dac1_sync_o <= 1'b1;
                            dac2_sync_o <= 1'b1;
                            sdi_o       <= 1'b0;
                            done1_o     <= ~last_two;
                            done2_o     <= last_two;
                            if (WAIT_CYCLES == 0) begin
                                busy_o <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                wait_cnt <= WW'(WAIT_CYCLES - 1);
                                state    <= WAIT;
                            end
                        end else begin
                            sclk_o  <= 1'b0;
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
